// File: rtl/ring_osc_meter_pkg.sv
`timescale 1ns/1ps
// ring_osc_meter_pkg
//   Shared definitions for the ring oscillator frequency meter.
//   - state_t            : measurement FSM states
//   - LUT_INIT_INV/_BUF  : SB_LUT4 truth tables for the ring cells
//   - gray2bin/bin2gray  : 32-bit wide code conversions; callers cast to their
//                          own width (upper bits zero-extended are harmless)
package ring_osc_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // O = 1 only when every input is 0: with I0 = chain_out and I1 = ~en this
   // gives chain_in = en & ~chain_out.
   localparam logic [15:0] LUT_INIT_INV = 16'd1;
   // O = 1 only for I0 = 1 with I1..I3 tied low: a buffer on I0.
   localparam logic [15:0] LUT_INIT_BUF = 16'd2;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/ring_osc_chain.sv
`timescale 1ns/1ps
// ring_osc_chain
//   One LUT ring oscillator plus its ring-domain Gray counter.
//   Ports:
//     resetn   in  async active-low clear of the Gray counter
//     en       in  ring enable; a disabled ring sits static low
//     ring_out out ring output (chain_out)
//     gray     out GRAY_W-bit Gray count of ring rising edges
//   For synthesis the ring is STAGES SB_LUT4 cells (one inverting, the rest
//   buffers). Otherwise a behavioural oscillator with half period
//   HALF_PERIOD_PS stands in for the combinational loop.
module ring_osc_chain
   import ring_osc_meter_pkg::*;
#(
   parameter int STAGES         = 1,
   parameter int GRAY_W         = 6,
   parameter int HALF_PERIOD_PS = 500
) (
   input  logic              resetn,
   input  logic              en,
   output logic              ring_out,
   output logic [GRAY_W-1:0] gray
);

   logic              w_ring;
   logic [GRAY_W-1:0] w_bin_nxt;
   logic [GRAY_W-1:0] r_bin;
   logic [GRAY_W-1:0] r_gray;

`ifdef SYNTHESIS
   logic [STAGES-1:0] w_node;
   logic              w_en_n;

   assign w_en_n = ~en;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_inv
         SB_LUT4 #(.LUT_INIT(LUT_INIT_INV)) u_lut (
            .O (w_node[0]),
            .I0(w_node[STAGES-1]),
            .I1(w_en_n),
            .I2(1'b0),
            .I3(1'b0)
         );
      end else begin : g_buf
         SB_LUT4 #(.LUT_INIT(LUT_INIT_BUF)) u_lut (
            .O (w_node[s]),
            .I0(w_node[s-1]),
            .I1(1'b0),
            .I2(1'b0),
            .I3(1'b0)
         );
      end
   end

   assign w_ring = w_node[STAGES-1];
`else
   logic r_osc = 1'b0;

   // Delay expressed in ns (timescale 1ns).
   always begin
      #(HALF_PERIOD_PS / 1000.0);
      r_osc <= en ? ~r_osc : 1'b0;
   end

   assign w_ring = r_osc;
`endif

   assign w_bin_nxt = r_bin + GRAY_W'(1);

   // Cleared only by resetn; holds its value while the ring is stopped.
   // The Gray code is registered so the clk-domain synchroniser never sees
   // more than one bit change per ring edge.
   always_ff @(posedge w_ring or negedge resetn) begin
      if (!resetn) begin
         r_bin  <= '0;
         r_gray <= '0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= GRAY_W'(bin2gray(32'(w_bin_nxt)));
      end
   end

   assign ring_out = w_ring;
   assign gray     = r_gray;

endmodule

// File: rtl/ring_osc_meter.sv
`timescale 1ns/1ps
// ring_osc_meter
//   Bank of NUM_RINGS LUT ring oscillators with a frequency meter. One ring
//   is enabled per measurement; its Gray edge counter is synchronised into
//   clk and the binary increments are accumulated (saturating) over a window
//   of clk cycles.
//   Ports:
//     clk      in  system clock
//     resetn   in  async active-low reset
//     start    in  measurement request, sampled in IDLE only
//     sel      in  ring index (>= NUM_RINGS selects ring 0), captured at start
//     window   in  measurement length in clk cycles, captured at start
//     busy     out measurement in progress
//     done     out one-cycle pulse, count/overflow updated
//     count    out rising edges counted in the window
//     overflow out accumulator saturated during last measurement
//     ring_mon out Gray bit 0 of the selected ring (raw, for a scope)
//   RING_HALF_PS packs one 32-bit half period per ring for the behavioural
//   ring model; it has no effect on the synthesised LUT rings.
module ring_osc_meter
   import ring_osc_meter_pkg::*;
#(
   parameter int NUM_RINGS  = 4,
   parameter int STAGES     = 1,
   parameter int GRAY_W     = 6,
   parameter int ACC_W      = 24,
   parameter int WIN_W      = 20,
   parameter int SETTLE_CYC = 4,
   parameter logic [NUM_RINGS*32-1:0] RING_HALF_PS = {NUM_RINGS{32'd500}},
   localparam int SEL_W     = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [SEL_W-1:0] sel,
   input  logic [WIN_W-1:0] window,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] count,
   output logic             overflow,
   output logic             ring_mon
);

   localparam int SETTLE_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

   // Returns {saturated, value}; value clamps to all-ones on carry out.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [GRAY_W-1:0] d);
      logic [ACC_W:0] s;
      s = {1'b0, a} + (ACC_W+1)'(d);
      if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
      return s;
   endfunction

   logic [GRAY_W-1:0]   w_gray  [NUM_RINGS];
   logic [NUM_RINGS-1:0] w_ring_out;
   logic [GRAY_W-1:0]   r_sync1 [NUM_RINGS];
   logic [GRAY_W-1:0]   r_sync2 [NUM_RINGS];

   state_t              r_state;
   logic [NUM_RINGS-1:0] r_en;
   logic [SEL_W-1:0]    r_sel;
   logic [SETTLE_W-1:0] r_settle;
   logic [WIN_W-1:0]    r_win;
   logic                r_ovf;
   logic                r_busy;
   logic                r_done;
   logic [ACC_W-1:0]    r_count;
   logic                r_overflow;
   logic [GRAY_W-1:0]   r_prev;
   logic [ACC_W-1:0]    r_acc;

   logic [SEL_W-1:0]    w_sel;
   logic [GRAY_W-1:0]   w_cur;
   logic [GRAY_W-1:0]   w_delta;
   logic [ACC_W:0]      w_sat;

   for (genvar g = 0; g < NUM_RINGS; g++) begin : g_ring
      ring_osc_chain #(
         .STAGES        (STAGES),
         .GRAY_W        (GRAY_W),
         .HALF_PERIOD_PS(int'(RING_HALF_PS[g*32 +: 32]))
      ) u_chain (
         .resetn  (resetn),
         .en      (r_en[g]),
         .ring_out(w_ring_out[g]),
         .gray    (w_gray[g])
      );
   end

   // Two-flop synchroniser per ring on the Gray bus.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_RINGS; i++) begin
            r_sync1[i] <= '0;
            r_sync2[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_RINGS; i++) begin
            r_sync1[i] <= w_gray[i];
            r_sync2[i] <= r_sync1[i];
         end
      end
   end

   assign w_sel   = (32'(sel) >= NUM_RINGS) ? '0 : sel;
   assign w_cur   = GRAY_W'(gray2bin(32'(r_sync2[r_sel])));
   // Modulo-2^GRAY_W difference absorbs counter wrap between samples.
   assign w_delta = w_cur - r_prev;
   assign w_sat   = sat_add(r_acc, w_delta);

   // Control FSM. done rises on the same edge that leaves DONE, so a start
   // seen alongside done is refused and the following IDLE cycle takes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_en       <= '0;
         r_sel      <= '0;
         r_settle   <= '0;
         r_win      <= '0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !r_done) begin
                  r_sel    <= w_sel;
                  r_win    <= window;
                  r_en     <= NUM_RINGS'(1) << w_sel;
                  r_settle <= SETTLE_W'(SETTLE_CYC);
                  r_busy   <= 1'b1;
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_settle == '0) begin
                  r_ovf   <= 1'b0;
                  r_state <= (r_win == '0) ? ST_DONE : ST_MEASURE;
               end else begin
                  r_settle <= r_settle - SETTLE_W'(1);
               end
            end
            ST_MEASURE: begin
               if (w_sat[ACC_W]) r_ovf <= 1'b1;
               r_win <= r_win - WIN_W'(1);
               if (r_win == WIN_W'(1)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_count    <= r_acc;
               r_overflow <= r_ovf;
               r_done     <= 1'b1;
               r_en       <= '0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Accumulator datapath; only meaningful between SETTLE exit and DONE.
   always_ff @(posedge clk) begin
      if (r_state == ST_SETTLE && r_settle == '0) begin
         r_prev <= w_cur;
         r_acc  <= '0;
      end else if (r_state == ST_MEASURE) begin
         r_prev <= w_cur;
         r_acc  <= w_sat[ACC_W-1:0];
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign ring_mon = w_gray[r_sel][0];

endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
// tb_ring_osc_meter
//   Scoreboard bench: each accepted measurement pushes its expected count
//   range, overflow flag and done cycle; monitors pop and compare on done.
//   dut_a: 4 rings, ring2 at 250 MHz, others 1 GHz, ACC_W=24.
//   dut_b: 3 rings, all 1 GHz, ACC_W=8 (saturation and sel clamping).
module tb_ring_osc_meter;

   localparam int SETTLE = 4;

   logic        clk;
   logic        resetn;
   logic        start_a, start_b;
   logic [1:0]  sel_a, sel_b;
   logic [19:0] window_a, window_b;
   logic        busy_a, busy_b;
   logic        done_a, done_b;
   logic [23:0] count_a;
   logic [7:0]  count_b;
   logic        overflow_a, overflow_b;
   logic        mon_a, mon_b;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint cyc      = 0;

   typedef struct {
      string  tag;
      longint lo;
      longint hi;
      longint ovf;
      longint done_cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ma, mb;

   ring_osc_meter #(
      .NUM_RINGS   (4),
      .ACC_W       (24),
      .RING_HALF_PS({32'd500, 32'd2000, 32'd500, 32'd500})
   ) dut_a (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start_a),
      .sel     (sel_a),
      .window  (window_a),
      .busy    (busy_a),
      .done    (done_a),
      .count   (count_a),
      .overflow(overflow_a),
      .ring_mon(mon_a)
   );

   ring_osc_meter #(
      .NUM_RINGS(3),
      .ACC_W    (8)
   ) dut_b (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start_b),
      .sel     (sel_b),
      .window  (window_b),
      .busy    (busy_b),
      .done    (done_b),
      .count   (count_b),
      .overflow(overflow_b),
      .ring_mon(mon_b)
   );

   // 100 MHz; offset so clk edges never coincide with ring edges.
   initial begin
      clk = 1'b0;
      #0.3;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got,
                        input longint lo, input longint hi);
      n_checks++;
      if (got < lo || got > hi) begin
         n_fail++;
         if (lo == hi)
            $display("FAIL %s got=%0d expected=%0d", tag, got, lo);
         else
            $display("FAIL %s got=%0d expected=%0d..%0d", tag, got, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && done_a) begin
         if (qa.size() == 0) begin
            check("a_unexpected_done", done_a, 0, 0);
         end else begin
            ma = qa.pop_front();
            check({ma.tag, "_count"},   count_a,    ma.lo,       ma.hi);
            check({ma.tag, "_ovf"},     overflow_a, ma.ovf,      ma.ovf);
            check({ma.tag, "_latency"}, cyc,        ma.done_cyc, ma.done_cyc);
            check({ma.tag, "_busy"},    busy_a,     0,           0);
         end
      end
   end

   always @(negedge clk) begin
      if (resetn && done_b) begin
         if (qb.size() == 0) begin
            check("b_unexpected_done", done_b, 0, 0);
         end else begin
            mb = qb.pop_front();
            check({mb.tag, "_count"},   count_b,    mb.lo,       mb.hi);
            check({mb.tag, "_ovf"},     overflow_b, mb.ovf,      mb.ovf);
            check({mb.tag, "_latency"}, cyc,        mb.done_cyc, mb.done_cyc);
            check({mb.tag, "_busy"},    busy_b,     0,           0);
         end
      end
   end

   task automatic issue_a(input string tag, input int s, input int w,
                          input longint lo, input longint hi, input longint ovf);
      exp_t e;
      @(negedge clk);
      start_a  = 1'b1;
      sel_a    = 2'(s);
      window_a = 20'(w);
      @(posedge clk);
      #1;
      check({tag, "_accept"}, busy_a, 1, 1);
      e = '{tag: tag, lo: lo, hi: hi, ovf: ovf, done_cyc: cyc + SETTLE + w + 2};
      qa.push_back(e);
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic issue_b(input string tag, input int s, input int w,
                          input longint lo, input longint hi, input longint ovf);
      exp_t e;
      @(negedge clk);
      start_b  = 1'b1;
      sel_b    = 2'(s);
      window_b = 20'(w);
      @(posedge clk);
      #1;
      check({tag, "_accept"}, busy_b, 1, 1);
      e = '{tag: tag, lo: lo, hi: hi, ovf: ovf, done_cyc: cyc + SETTLE + w + 2};
      qb.push_back(e);
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic wait_a(input int maxc);
      int n = 0;
      while (qa.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (qa.size() != 0) begin
         check("a_done_timeout", qa.size(), 0, 0);
         qa.delete();
      end
   endtask

   task automatic wait_b(input int maxc);
      int n = 0;
      while (qb.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (qb.size() != 0) begin
         check("b_done_timeout", qb.size(), 0, 0);
         qb.delete();
      end
   endtask

   initial begin
      int n;
      longint g0, g1, g3;
      exp_t e;

      resetn   = 1'b0;
      start_a  = 1'b0;
      sel_a    = '0;
      window_a = '0;
      start_b  = 1'b0;
      sel_b    = '0;
      window_b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",     busy_a,     0, 0);
      check("rst_done",     done_a,     0, 0);
      check("rst_count",    count_a,    0, 0);
      check("rst_overflow", overflow_a, 0, 0);
      check("rst_en",       dut_a.r_en, 0, 0);
      check("rst_busy_b",   busy_b,     0, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // 1 GHz ring0, 100-cycle window.
      issue_a("t1", 0, 100, 998, 1002, 0);
      n = 0;
      while (!done_a && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t1_done_seen", done_a, 1, 1);

      // start held from the done cycle: refused there, taken one cycle later.
      start_a  = 1'b1;
      sel_a    = 2'd3;
      window_a = 20'd0;
      @(posedge clk);
      #1;
      check("t3_refused_at_done", busy_a, 0, 0);
      @(posedge clk);
      #1;
      check("t3_accept", busy_a, 1, 1);
      e = '{tag: "t3", lo: 0, hi: 0, ovf: 0, done_cyc: cyc + SETTLE + 2};
      qa.push_back(e);
      @(negedge clk);
      start_a = 1'b0;
      check("t1_count_hold", count_a, 998, 1002);
      wait_a(50);

      // ring2 at 250 MHz; unselected rings must not move.
      g0 = longint'(dut_a.w_gray[0]);
      g1 = longint'(dut_a.w_gray[1]);
      g3 = longint'(dut_a.w_gray[3]);
      issue_a("t4", 2, 1000, 2498, 2502, 0);
      check("t4_en", dut_a.r_en, 4, 4);
      wait_a(1100);
      check("t4_ring0_held", dut_a.w_gray[0], g0, g0);
      check("t4_ring1_held", dut_a.w_gray[1], g1, g1);
      check("t4_ring3_held", dut_a.w_gray[3], g3, g3);

      // start during MEASURE is ignored: one done only.
      issue_a("t5", 0, 50, 498, 502, 0);
      repeat (20) @(negedge clk);
      start_a  = 1'b1;
      sel_a    = 2'd1;
      window_a = 20'd3;
      @(negedge clk);
      start_a = 1'b0;
      check("t5_en_kept", dut_a.r_en, 1, 1);
      wait_a(100);
      repeat (20) @(negedge clk);

      // Saturation with ACC_W=8; sel=3 on a 3-ring bank selects ring 0.
      issue_b("t6", 3, 100, 255, 255, 1);
      check("t6_sel_clamp_en", dut_b.r_en, 1, 1);
      wait_b(150);
      issue_b("t7", 1, 10, 98, 102, 0);
      wait_b(50);

      // Reset in the middle of a measurement.
      @(negedge clk);
      start_a  = 1'b1;
      sel_a    = 2'd0;
      window_a = 20'd1000;
      @(negedge clk);
      start_a = 1'b0;
      repeat (50) @(negedge clk);
      check("t8_busy_before", busy_a, 1, 1);
      resetn = 1'b0;
      #1;
      check("t8_busy",     busy_a,          0, 0);
      check("t8_done",     done_a,          0, 0);
      check("t8_count",    count_a,         0, 0);
      check("t8_overflow", overflow_a,      0, 0);
      check("t8_en",       dut_a.r_en,      0, 0);
      check("t8_gray0",    dut_a.w_gray[0], 0, 0);
      check("t8_count_b",  count_b,         0, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (1100) @(negedge clk);
      check("t8_idle_after", busy_a, 0, 0);
      check("t8_count_after", count_a, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
